// File: rtl/upower_fetch_queue.sv
// Instruction fetch queue: one outstanding word fetch at a time, a DEPTH-entry
// FIFO of {instruction, pc} pairs, and redirect flushing with stale-response discard.
module upower_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [4:0]  queue_count
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          in_flight_q, in_flight_d;
    logic          discard_q, discard_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [4:0]    count_q, count_d;

    logic          issue_s;
    logic          pop_s;
    logic          push_s;

    // A response is only accepted for a request this block actually issued, which
    // also drops anything that shows up right after reset.
    assign issue_s = !reset && !redirect && !in_flight_q && (count_q < DEPTH_C);
    assign pop_s   = (count_q != 5'd0) && instr_ready;
    assign push_s  = imem_valid && in_flight_q && !discard_q && ((count_q < DEPTH_C) || pop_s);

    assign imem_req    = issue_s;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != 5'd0);
    assign instr_out   = mem_instr_q[head_q];
    assign instr_pc    = mem_pc_q[head_q];
    assign queue_count = count_q;

    // Next-state computation; redirect wins over any push/pop in the same cycle.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        in_flight_d = issue_s;
        discard_d   = 1'b0;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = 5'd0;
            discard_d  = in_flight_q && !imem_valid;
        end else begin
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
                req_addr_d = fetch_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                tail_d = tail_q + 1'b1;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + 1'b1;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= RESET_PC;
            in_flight_q <= 1'b0;
            discard_q   <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 5'd0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Queue storage write at the tail; contents need no reset since count gates validity.
    always_ff @(posedge clock) begin
        if (!reset && !redirect && push_s) begin
            mem_instr_q[tail_q] <= imem_data;
            mem_pc_q[tail_q]    <= req_addr_q;
        end
    end

endmodule
